// File: rtl/load_store_unit.sv
// Memory-access stage: takes decoded loads/stores from execute, drives a
// req/gnt/rvalid data-memory port and returns extended load data to write-back.
module load_store_unit #(
  parameter int ADDR_WIDTH    = 32,
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic                  ex_is_store,
  input  logic [2:0]            ex_funct3,
  input  logic [31:0]           ex_addr,
  input  logic [31:0]           ex_wdata,
  input  logic [4:0]            ex_rd,
  input  logic                  flush,
  output logic                  lsu_ready,
  output logic                  lsu_busy,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [31:0]           dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [31:0]           dmem_rdata,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [31:0]           wb_data,
  output logic                  lsu_misaligned,
  output logic                  lsu_illegal,
  output logic [31:0]           lsu_fault_addr
);

  // Handshake: dmem_req/addr/be/we/wdata stay stable from the first REQ cycle
  // until the cycle dmem_gnt is seen high; dmem_rvalid only counts in WAIT states.
  typedef enum logic [1:0] {IDLE, REQ, WAIT, WAIT_DISCARD} state_e;

  state_e                state_q;
  logic                  dmem_req_q, dmem_we_q;
  logic [ADDR_WIDTH-1:0] dmem_addr_q;
  logic [3:0]            dmem_be_q;
  logic [31:0]           dmem_wdata_q;
  logic                  wb_valid_q;
  logic [4:0]            wb_rd_q;
  logic [31:0]           wb_data_q;
  logic                  misaligned_q, illegal_q;
  logic [31:0]           fault_addr_q;
  logic                  is_load_q;
  logic [2:0]            funct3_q;
  logic [1:0]            lane_q;
  logic [4:0]            rd_q;

  logic                  accept;
  logic                  illegal_op;
  logic                  misaligned_op;
  logic [1:0]            size;
  logic [1:0]            lane_d;
  logic [3:0]            be_d;
  logic [31:0]           wdata_d;
  logic [31:0]           shifted;
  logic [31:0]           load_data;

  assign lsu_ready = (state_q == IDLE);
  assign lsu_busy  = (state_q != IDLE) ||
                     (ex_valid && (ex_is_load || ex_is_store) && lsu_ready);
  assign accept    = (state_q == IDLE) && ex_valid &&
                     (ex_is_load || ex_is_store) && !flush;

  always_comb begin
    size   = ex_funct3[1:0];
    lane_d = ex_addr[1:0];
    // Natural alignment; only has an effect when misaligned accesses are not trapped.
    if (size == 2'b01) begin
      lane_d[0] = 1'b0;
    end else if (size != 2'b00) begin
      lane_d = 2'b00;
    end
    misaligned_op = ((size == 2'b01) && ex_addr[0]) ||
                    ((size == 2'b10) && (ex_addr[1:0] != 2'b00));
    illegal_op = (ex_is_load && ex_is_store) ||
                 (ex_is_load && ((ex_funct3 == 3'b011) || (ex_funct3 == 3'b110) ||
                                 (ex_funct3 == 3'b111))) ||
                 (ex_is_store && (ex_funct3 >= 3'b011));
    case (size)
      2'b00:   begin be_d = 4'b0001 << lane_d; wdata_d = {4{ex_wdata[7:0]}};  end
      2'b01:   begin be_d = 4'b0011 << lane_d; wdata_d = {2{ex_wdata[15:0]}}; end
      default: begin be_d = 4'b1111;           wdata_d = ex_wdata;            end
    endcase
  end

  always_comb begin
    shifted = dmem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= 4'd0;
      dmem_wdata_q <= 32'd0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= 32'd0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      fault_addr_q <= 32'd0;
      is_load_q    <= 1'b0;
      funct3_q     <= 3'd0;
      lane_q       <= 2'd0;
      rd_q         <= 5'd0;
    end else begin
      wb_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (illegal_op) begin
              illegal_q    <= 1'b1;
              fault_addr_q <= ex_addr;
            end else if (MISALIGN_TRAP && misaligned_op) begin
              misaligned_q <= 1'b1;
              fault_addr_q <= ex_addr;
            end else begin
              state_q      <= REQ;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= ex_is_store;
              dmem_addr_q  <= {ex_addr[ADDR_WIDTH-1:2], 2'b00};
              dmem_be_q    <= be_d;
              dmem_wdata_q <= wdata_d;
              is_load_q    <= ex_is_load;
              funct3_q     <= ex_funct3;
              lane_q       <= lane_d;
              rd_q         <= ex_rd;
            end
          end
        end
        REQ: begin
          // A grant wins over a same-cycle flush: the access already happened.
          if (dmem_gnt) begin
            dmem_req_q <= 1'b0;
            if (!is_load_q) begin
              state_q <= IDLE;
            end else if (flush) begin
              state_q <= WAIT_DISCARD;
            end else begin
              state_q <= WAIT;
            end
          end else if (flush) begin
            dmem_req_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            state_q <= IDLE;
            if (!flush) begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= load_data;
              wb_rd_q    <= rd_q;
            end
          end else if (flush) begin
            state_q <= WAIT_DISCARD;
          end
        end
        WAIT_DISCARD: begin
          if (dmem_rvalid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req       = dmem_req_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_be        = dmem_be_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign lsu_misaligned = misaligned_q;
  assign lsu_illegal    = illegal_q;
  assign lsu_fault_addr = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_is_load, ex_is_store, flush;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        lsu_ready, lsu_busy, dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lsu_misaligned, lsu_illegal;
  logic [31:0] lsu_fault_addr;

  load_store_unit dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd), .flush(flush), .lsu_ready(lsu_ready),
    .lsu_busy(lsu_busy), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lsu_misaligned(lsu_misaligned), .lsu_illegal(lsu_illegal),
    .lsu_fault_addr(lsu_fault_addr)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  bit          known  = 1'b0;
  logic [31:0] exp_q[$];

  // Model: one outstanding access record plus expected registered outputs.
  bit          m_active, m_load, m_granted, m_discard;
  logic [2:0]  m_f3;
  int          m_lane;
  logic [4:0]  m_rd;
  logic        e_req, e_we, e_wb_valid, e_mis, e_ill;
  logic [31:0] e_addr, e_wdata, e_fault;
  logic [3:0]  e_be;
  logic [4:0]  e_wb_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_result(input logic [2:0] f3, input int lane,
                                              input logic [31:0] rdata);
    logic [31:0] v, b, h;
    v = rdata >> (8 * lane);
    b = v % 256;
    h = v % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  task automatic model_next();
    int  sz, lane;
    bit  bad, mis;
    e_wb_valid = 1'b0;
    e_mis      = 1'b0;
    e_ill      = 1'b0;
    if (rst) begin
      m_active = 0; m_granted = 0; m_discard = 0;
      e_req = 0; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
      e_wb_rd = 0; e_fault = 0;
      exp_q.delete();
    end else if (!m_active) begin
      if (ex_valid && (ex_is_load || ex_is_store) && !flush) begin
        sz   = int'(ex_funct3) % 4;
        lane = int'(ex_addr % 4);
        bad  = (ex_is_load && ex_is_store) ||
               (ex_is_load && (ex_funct3 == 3 || ex_funct3 >= 6)) ||
               (ex_is_store && ex_funct3 >= 3);
        mis  = (sz == 1 && lane % 2 == 1) || (sz == 2 && lane != 0);
        if (bad) begin
          e_ill = 1'b1; e_fault = ex_addr;
        end else if (mis) begin
          e_mis = 1'b1; e_fault = ex_addr;
        end else begin
          e_req   = 1'b1;
          e_we    = ex_is_store;
          e_addr  = ex_addr - lane;
          e_be    = (sz == 0) ? 4'(1 << lane) : (sz == 1) ? 4'(3 << lane) : 4'hF;
          e_wdata = (sz == 0) ? (ex_wdata % 256) * 32'h0101_0101 :
                    (sz == 1) ? (ex_wdata % 65536) * 32'h0001_0001 : ex_wdata;
          m_active = 1; m_granted = 0; m_discard = 0;
          m_load = ex_is_load; m_f3 = ex_funct3; m_lane = lane; m_rd = ex_rd;
        end
      end
    end else if (!m_granted) begin
      if (dmem_gnt) begin
        e_req = 1'b0;
        if (!m_load) m_active = 0;
        else begin m_granted = 1; m_discard = flush; end
      end else if (flush) begin
        e_req = 1'b0;
        m_active = 0;
      end
    end else begin
      if (dmem_rvalid) begin
        if (!m_discard && !flush) begin
          e_wb_valid = 1'b1;
          e_wb_rd    = m_rd;
          exp_q.push_back(load_result(m_f3, m_lane, dmem_rdata));
        end
        m_active = 0;
      end else if (flush) begin
        m_discard = 1;
      end
    end
  endtask

  task automatic check_regs();
    logic [31:0] exp_data;
    chk("dmem_req", dmem_req, e_req);
    if (e_req) begin
      chk("dmem_we", dmem_we, e_we);
      chk("dmem_addr", dmem_addr, e_addr);
      chk("dmem_be", dmem_be, e_be);
      if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
    end
    chk("wb_valid", wb_valid, e_wb_valid);
    if (e_wb_valid) begin
      chk("wb_rd", wb_rd, e_wb_rd);
      exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      chk("wb_data", wb_data, exp_data);
    end
    chk("lsu_misaligned", lsu_misaligned, e_mis);
    chk("lsu_illegal", lsu_illegal, e_ill);
    if (e_mis || e_ill) chk("lsu_fault_addr", lsu_fault_addr, e_fault);
  endtask

  // One cycle: inputs were set at the negedge; check combinational outputs,
  // advance the model across the posedge, then check registered outputs.
  task automatic step();
    #1;
    if (known) begin
      chk("lsu_ready", lsu_ready, !m_active);
      chk("lsu_busy", lsu_busy,
          m_active || (ex_valid && (ex_is_load || ex_is_store)));
    end
    model_next();
    @(negedge clk);
    known = 1'b1;
    check_regs();
  endtask

  // Driver tasks
  task automatic set_idle();
    rst = 0; ex_valid = 0; ex_is_load = 0; ex_is_store = 0; flush = 0;
    dmem_gnt = 0; dmem_rvalid = 0;
  endtask

  task automatic issue(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1; ex_is_load = ld; ex_is_store = !ld;
    ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
    step();
    ex_valid = 0; ex_is_load = 0; ex_is_store = 0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a,
                         input logic [4:0] rd, input logic [31:0] rdata);
    issue(1'b1, f3, a, 32'd0, rd);
    dmem_gnt = 1; step();
    dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = rdata; step();
    dmem_rvalid = 0;
  endtask

  initial begin
    set_idle();
    ex_funct3 = 0; ex_addr = 0; ex_wdata = 0; ex_rd = 0; dmem_rdata = 0;
    rst = 1;
    @(negedge clk);
    step(); step();
    rst = 0;

    // Reset state
    chk("rst_req", dmem_req, 0);        chk("rst_we", dmem_we, 0);
    chk("rst_be", dmem_be, 0);          chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);     chk("rst_wb_rd", wb_rd, 0);
    chk("rst_mis", lsu_misaligned, 0);  chk("rst_ill", lsu_illegal, 0);
    chk("rst_fault", lsu_fault_addr, 0); chk("rst_ready", lsu_ready, 1);

    // SW, granted in its first REQ cycle
    issue(1'b0, 3'd2, 32'h104, 32'hDEAD_BEEF, 5'd0);
    chk("sw_req", dmem_req, 1);  chk("sw_we", dmem_we, 1);
    chk("sw_addr", dmem_addr, 32'h104); chk("sw_be", dmem_be, 4'hF);
    chk("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
    dmem_gnt = 1; step(); dmem_gnt = 0;
    chk("sw_req_drop", dmem_req, 0);  chk("sw_ready", lsu_ready, 1);

    // SB with grant held off for 3 cycles
    issue(1'b0, 3'd0, 32'h203, 32'h0000_00A5, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sb_req", dmem_req, 1); chk("sb_be", dmem_be, 4'b1000);
      chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5); chk("sb_busy", lsu_busy, 1);
    end
    dmem_gnt = 1; step(); dmem_gnt = 0;

    // Load extension
    do_load(3'd0, 32'h2, 5'd5, 32'h0080_0000);
    chk("lb_data", wb_data, 32'hFFFF_FF80); chk("lb_rd", wb_rd, 5);
    do_load(3'd4, 32'h2, 5'd6, 32'h0080_0000);
    chk("lbu_data", wb_data, 32'h0000_0080);
    do_load(3'd1, 32'h2, 5'd9, 32'h8001_0000);
    chk("lh_data", wb_data, 32'hFFFF_8001); chk("lh_rd", wb_rd, 9);

    // Misaligned and illegal
    issue(1'b1, 3'd2, 32'h6, 32'd0, 5'd1);
    chk("mis_pulse", lsu_misaligned, 1); chk("mis_fault", lsu_fault_addr, 32'h6);
    chk("mis_noreq", dmem_req, 0);
    step();
    chk("mis_drop", lsu_misaligned, 0); chk("mis_noreq2", dmem_req, 0);
    issue(1'b1, 3'd7, 32'h30, 32'd0, 5'd1);
    chk("ill_pulse", lsu_illegal, 1); chk("ill_fault", lsu_fault_addr, 32'h30);

    // Flush during WAIT, then a normal load
    issue(1'b1, 3'd2, 32'h10, 32'd0, 5'd3);
    dmem_gnt = 1; step(); dmem_gnt = 0;
    flush = 1; step(); flush = 0;
    step();
    chk("flush_busy", lsu_busy, 1);
    dmem_rvalid = 1; dmem_rdata = 32'h5555_AAAA; step(); dmem_rvalid = 0;
    chk("flush_no_wb", wb_valid, 0); chk("flush_ready", lsu_ready, 1);
    do_load(3'd2, 32'h40, 5'd7, 32'h1234_5678);
    chk("after_flush_wb", wb_valid, 1); chk("after_flush_data", wb_data, 32'h1234_5678);

    // Reset while waiting for data
    issue(1'b1, 3'd2, 32'h20, 32'd0, 5'd4);
    dmem_gnt = 1; step(); dmem_gnt = 0;
    rst = 1; step(); rst = 0;
    chk("rstw_req", dmem_req, 0); chk("rstw_ready", lsu_ready, 1);
    dmem_rvalid = 1; step(); dmem_rvalid = 0;
    chk("rstw_no_wb", wb_valid, 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      int kind;
      rst       = ($urandom_range(0, 149) == 0);
      ex_valid  = $urandom_range(0, 1);
      kind      = $urandom_range(0, 9);
      ex_is_load  = (kind == 1) || (kind >= 2 && kind <= 5);
      ex_is_store = (kind == 1) || (kind >= 6);
      ex_funct3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                               : 3'($urandom_range(0, 2));
      if (ex_is_load && !ex_is_store && $urandom_range(0, 3) == 0)
        ex_funct3 = 3'($urandom_range(4, 5));
      ex_addr   = $urandom();
      if ($urandom_range(0, 1) == 0) ex_addr[1:0] = 2'b00;
      ex_wdata  = $urandom();
      ex_rd     = 5'($urandom_range(0, 31));
      flush     = ($urandom_range(0, 9) == 0);
      dmem_gnt  = ($urandom_range(0, 2) != 0);
      dmem_rvalid = ($urandom_range(0, 2) == 0);
      dmem_rdata  = $urandom();
      step();
    end

    set_idle();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
